// File: rtl/chroma_fir_upsampler.sv
// 2x horizontal chroma upsampler: even phase passes u[j], odd phase is a 6-tap symmetric
// FIR with edge replication, computed on one multiplier shared across taps and channels.
module chroma_fir_upsampler #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 2,
    parameter int LINE_LEN = 160,
    parameter int C0       = 21,
    parameter int C1       = 52,
    parameter int C2       = 159
) (
    input  logic                       CLOCK_50_I,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_sol,
    input  logic [CHANNELS*DATA_W-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CHANNELS*DATA_W-1:0] out_even,
    output logic [CHANNELS*DATA_W-1:0] out_odd,
    output logic                       out_eol
);
    localparam int ACC_W = DATA_W + 11;
    localparam int CNT_W = $clog2(LINE_LEN + 1);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic signed [ACC_W-1:0] ROUND      = {{(ACC_W-9){1'b0}}, 9'd128};
    localparam logic signed [ACC_W-1:0] SAMPLE_MAX = {{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_MAC   = 3'd2;
    localparam logic [2:0] ST_OUT   = 3'd3;
    localparam logic [2:0] ST_FLUSH = 3'd4;

    logic [2:0]                state_r, next_state_s;
    logic                      in_ready_r;
    logic [CNT_W-1:0]          rx_cnt_r, rx_inc_s;
    logic [1:0]                flush_cnt_r;
    logic [CH_W-1:0]           mac_ch_r;
    logic [1:0]                mac_tap_r;
    logic signed [ACC_W-1:0]   acc_r, acc_next_s, prod_s, res_s;
    logic [DATA_W:0]           sum_s;
    logic [ACC_W-1:0]          coef_s;
    logic [DATA_W-1:0]         clip_s;
    logic [DATA_W-1:0]         win_r [CHANNELS][6];
    logic                      accept_s, load_sol_s, shift_in_s, out_fire_s, mac_last_s;
    logic                      out_valid_r, out_eol_r;
    logic [CHANNELS*DATA_W-1:0] out_even_r, out_odd_r;

    assign accept_s   = in_valid & in_ready_r;
    assign load_sol_s = accept_s & in_sol;
    assign shift_in_s = accept_s & ~in_sol & (state_r == ST_LOAD);
    assign out_fire_s = out_valid_r & out_ready;
    assign rx_inc_s   = rx_cnt_r + CNT_W'(1'b1);
    assign mac_last_s = (state_r == ST_MAC) && (mac_tap_r == 2'd2) &&
                        (mac_ch_r == CH_W'(CHANNELS - 1));

    // Line-sequencing state machine: next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (load_sol_s) next_state_s = ST_LOAD;
                else            next_state_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (load_sol_s)                                   next_state_s = ST_LOAD;
                else if (shift_in_s && (rx_inc_s >= CNT_W'(3'd4))) next_state_s = ST_MAC;
                else                                              next_state_s = ST_LOAD;
            end
            ST_MAC: begin
                if (mac_last_s) next_state_s = ST_OUT;
                else            next_state_s = ST_MAC;
            end
            ST_OUT: begin
                if (out_fire_s) begin
                    if (rx_cnt_r < CNT_W'(LINE_LEN)) next_state_s = ST_LOAD;
                    else if (flush_cnt_r < 2'd3)     next_state_s = ST_FLUSH;
                    else                             next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_OUT;
                end
            end
            ST_FLUSH: next_state_s = ST_MAC;
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // Tap operand and coefficient selection for the shared multiplier
    always_comb begin
        sum_s  = {(DATA_W+1){1'b0}};
        coef_s = ACC_W'(C0);
        case (mac_tap_r)
            2'd0: begin
                sum_s  = {1'b0, win_r[mac_ch_r][0]} + {1'b0, win_r[mac_ch_r][5]};
                coef_s = ACC_W'(C0);
            end
            2'd1: begin
                sum_s  = {1'b0, win_r[mac_ch_r][1]} + {1'b0, win_r[mac_ch_r][4]};
                coef_s = ACC_W'(C1);
            end
            2'd2: begin
                sum_s  = {1'b0, win_r[mac_ch_r][2]} + {1'b0, win_r[mac_ch_r][3]};
                coef_s = ACC_W'(C2);
            end
            default: begin
                sum_s  = {(DATA_W+1){1'b0}};
                coef_s = ACC_W'(C0);
            end
        endcase
        prod_s = $signed({{(ACC_W-DATA_W-1){1'b0}}, sum_s} * coef_s);
    end

    // Accumulate step; the outer taps carry the rounding constant, the middle pair subtracts
    always_comb begin
        acc_next_s = acc_r;
        case (mac_tap_r)
            2'd0:    acc_next_s = prod_s + ROUND;
            2'd1:    acc_next_s = acc_r - prod_s;
            2'd2:    acc_next_s = acc_r + prod_s;
            default: acc_next_s = acc_r;
        endcase
        res_s = acc_next_s >>> 4'd8;
        if (res_s[ACC_W-1])           clip_s = {DATA_W{1'b0}};
        else if (res_s > SAMPLE_MAX)  clip_s = {DATA_W{1'b1}};
        else                          clip_s = res_s[DATA_W-1:0];
    end

    // Control registers: state, advertised ready, line counters, MAC sequencing
    always_ff @(posedge CLOCK_50_I or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            rx_cnt_r    <= {CNT_W{1'b0}};
            flush_cnt_r <= 2'd0;
            mac_ch_r    <= {CH_W{1'b0}};
            mac_tap_r   <= 2'd0;
            acc_r       <= {ACC_W{1'b0}};
        end else begin
            state_r    <= next_state_s;
            in_ready_r <= (next_state_s == ST_IDLE) || (next_state_s == ST_LOAD);
            if (load_sol_s) begin
                rx_cnt_r    <= CNT_W'(1'b1);
                flush_cnt_r <= 2'd0;
            end else if (shift_in_s) begin
                rx_cnt_r <= rx_inc_s;
            end else if (state_r == ST_FLUSH) begin
                flush_cnt_r <= flush_cnt_r + 2'd1;
            end else if (out_fire_s && (next_state_s == ST_IDLE)) begin
                rx_cnt_r    <= {CNT_W{1'b0}};
                flush_cnt_r <= 2'd0;
            end
            if (state_r == ST_MAC) begin
                acc_r <= acc_next_s;
                if (mac_tap_r == 2'd2) begin
                    mac_tap_r <= 2'd0;
                    mac_ch_r  <= mac_last_s ? {CH_W{1'b0}} : mac_ch_r + CH_W'(1'b1);
                end else begin
                    mac_tap_r <= mac_tap_r + 2'd1;
                end
            end else begin
                mac_ch_r  <= {CH_W{1'b0}};
                mac_tap_r <= 2'd0;
            end
        end
    end

    // Sample windows: start of line replicates sample 0; flush replicates the last sample
    always_ff @(posedge CLOCK_50_I or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++)
                for (int k = 0; k < 6; k++)
                    win_r[c][k] <= {DATA_W{1'b0}};
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (load_sol_s) begin
                    for (int k = 0; k < 6; k++)
                        win_r[c][k] <= in_data[c*DATA_W +: DATA_W];
                end else if (shift_in_s || (state_r == ST_FLUSH)) begin
                    for (int k = 0; k < 5; k++)
                        win_r[c][k] <= win_r[c][k+1];
                    win_r[c][5] <= shift_in_s ? in_data[c*DATA_W +: DATA_W] : win_r[c][5];
                end
            end
        end
    end

    // Output pair registers, held until the downstream handshake
    always_ff @(posedge CLOCK_50_I or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_eol_r   <= 1'b0;
            out_even_r  <= {(CHANNELS*DATA_W){1'b0}};
            out_odd_r   <= {(CHANNELS*DATA_W){1'b0}};
        end else begin
            if ((state_r == ST_MAC) && (mac_tap_r == 2'd2)) begin
                out_odd_r[mac_ch_r*DATA_W +: DATA_W]  <= clip_s;
                out_even_r[mac_ch_r*DATA_W +: DATA_W] <= win_r[mac_ch_r][2];
            end
            if (mac_last_s) begin
                out_valid_r <= 1'b1;
                out_eol_r   <= (flush_cnt_r == 2'd3);
            end else if (out_fire_s) begin
                out_valid_r <= 1'b0;
                out_eol_r   <= 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_eol   = out_eol_r;
    assign out_even  = out_even_r;
    assign out_odd   = out_odd_r;
endmodule

// File: tb/tb_chroma_fir_upsampler.sv
// Scoreboarded directed bench: a LINE_LEN=8 instance carries the edge, clip, backpressure,
// restart and reset scenarios; a LINE_LEN=160 instance carries the constant-line run.
module tb_chroma_fir_upsampler;
    localparam int LEN  = 8;
    localparam int LLEN = 160;

    typedef struct packed {
        logic [15:0] even;
        logic [15:0] odd;
        logic        eol;
    } pair_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, in_sol = 1'b0, out_ready = 1'b1;
    logic [15:0] in_data = 16'd0;
    logic        in_ready, out_valid, out_eol;
    logic [15:0] out_even, out_odd;

    logic        l_in_valid = 1'b0, l_in_sol = 1'b0, l_out_ready = 1'b1;
    logic [15:0] l_in_data = 16'd0;
    logic        l_in_ready, l_out_valid, l_out_eol;
    logic [15:0] l_out_even, l_out_odd;

    int          checks = 0, failures = 0, pairs_done = 0;
    int          l_cnt = 0, cyc = 0, l_last = 0, l_acc, l_n;
    pair_t       exp_q[$];
    pair_t       mon_e;
    logic [7:0]  line_u [2][LEN];

    always #5 clk = ~clk;

    chroma_fir_upsampler #(.DATA_W(8), .CHANNELS(2), .LINE_LEN(LEN)) dut (
        .CLOCK_50_I(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_sol(in_sol), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_even(out_even), .out_odd(out_odd), .out_eol(out_eol));

    chroma_fir_upsampler #(.DATA_W(8), .CHANNELS(2), .LINE_LEN(LLEN)) dut_long (
        .CLOCK_50_I(clk), .reset(reset), .in_valid(l_in_valid), .in_ready(l_in_ready),
        .in_sol(l_in_sol), .in_data(l_in_data), .out_valid(l_out_valid), .out_ready(l_out_ready),
        .out_even(l_out_even), .out_odd(l_out_odd), .out_eol(l_out_eol));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int clampi(input int i);
        if (i < 0) return 0;
        if (i > LEN - 1) return LEN - 1;
        return i;
    endfunction

    // Reference odd sample straight from the filter definition
    function automatic logic [7:0] ref_odd(input int c, input int j);
        int w[6];
        int a;
        for (int k = 0; k < 6; k++) w[k] = int'(line_u[c][clampi(j - 2 + k)]);
        a = 21 * (w[0] + w[5]) - 52 * (w[1] + w[4]) + 159 * (w[2] + w[3]) + 128;
        a = a >>> 8;
        if (a < 0) return 8'd0;
        if (a > 255) return 8'd255;
        return 8'(a);
    endfunction

    task automatic push_pairs(input int n);
        pair_t p;
        for (int j = 0; j < n; j++) begin
            p.even = {line_u[1][j], line_u[0][j]};
            p.odd  = {ref_odd(1, j), ref_odd(0, j)};
            p.eol  = (j == LEN - 1);
            exp_q.push_back(p);
        end
    endtask

    task automatic drive_word(input logic [15:0] d, input logic s);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sol   = s;
        while (in_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 32'(n < 300), 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_sol   = 1'b0;
    endtask

    task automatic send_words(input int n);
        for (int i = 0; i < n; i++) drive_word({line_u[1][i], line_u[0][i]}, i == 0);
    endtask

    task automatic wait_empty();
        int n = 0;
        while (exp_q.size() > 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("drain", 32'(exp_q.size()), 0);
    endtask

    task automatic bp_watch(input int at_pair);
        int n = 0;
        while (!(out_valid === 1'b1 && pairs_done == at_pair) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("bp_reached", 32'(n < 1000), 1);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 1);
            check("bp_even", 32'(out_even), 32'(exp_q[0].even));
            check("bp_odd", 32'(out_odd), 32'(exp_q[0].odd));
            check("bp_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard for the short instance
    always @(negedge clk) begin
        #1;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            check("pair_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("even", 32'(out_even), 32'(mon_e.even));
                check("odd", 32'(out_odd), 32'(mon_e.odd));
                check("eol", 32'(out_eol), 32'(mon_e.eol));
            end
            pairs_done++;
        end
    end

    // Constant-line monitor for the long instance
    always @(negedge clk) begin
        #1;
        if (l_out_valid === 1'b1 && l_out_ready === 1'b1) begin
            check("long_even", 32'(l_out_even), 32'h3264);
            check("long_odd", 32'(l_out_odd), 32'h3264);
            check("long_eol", 32'(l_out_eol), 32'(l_cnt == LLEN - 1));
            if (l_cnt > 0) check("long_spacing", 32'(cyc - l_last), 8);
            l_last = cyc;
            l_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_eol", 32'(out_eol), 0);
        check("rst_out_even", 32'(out_even), 0);
        check("rst_out_odd", 32'(out_odd), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 1);

        // Constant line, always-valid input on the long instance
        l_in_data = {8'd50, 8'd100};
        l_in_sol = 1'b1;
        l_in_valid = 1'b1;
        l_acc = 0;
        l_n = 0;
        while (l_acc < LLEN && l_n < 5000) begin
            if (l_in_ready === 1'b1) begin
                @(negedge clk);
                l_acc++;
                l_in_sol = 1'b0;
            end else begin
                @(negedge clk);
            end
            l_n++;
        end
        l_in_valid = 1'b0;
        check("long_accepts", 32'(l_acc), LLEN);
        l_n = 0;
        while (l_cnt < LLEN && l_n < 2000) begin
            @(negedge clk);
            l_n++;
        end
        repeat (20) @(negedge clk);
        check("long_pairs", 32'(l_cnt), LLEN);

        // Stray word in IDLE
        pairs_done = 0;
        drive_word(16'h1234, 1'b0);
        repeat (30) @(negedge clk);
        check("stray_no_valid", 32'(out_valid), 0);
        check("stray_no_pairs", 32'(pairs_done), 0);

        // Ramp with line edges, backpressure on pair 3
        for (int i = 0; i < LEN; i++) begin
            line_u[0][i] = 8'(10 * (i + 1));
            line_u[1][i] = 8'(200 - 20 * i);
        end
        push_pairs(LEN);
        pairs_done = 0;
        fork
            send_words(LEN);
            bp_watch(3);
        join
        wait_empty();
        check("ramp_pairs", 32'(pairs_done), LEN);

        // Clipping both ways, each pattern on each channel
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < LEN; i++) begin
                line_u[r][i]     = (i == 2 || i == 3) ? 8'd255 : 8'd0;
                line_u[1 - r][i] = (i == 2 || i == 3) ? 8'd0 : 8'd255;
            end
            push_pairs(LEN);
            send_words(LEN);
            wait_empty();
        end

        // Two random lines back to back
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < LEN; i++) begin
                line_u[0][i] = 8'($urandom_range(0, 255));
                line_u[1][i] = 8'($urandom_range(0, 255));
            end
            push_pairs(LEN);
            send_words(LEN);
        end
        wait_empty();

        // Restart after 5 samples: aborted line yields only its pairs 0 and 1
        for (int i = 0; i < LEN; i++) begin
            line_u[0][i] = 8'($urandom_range(0, 255));
            line_u[1][i] = 8'($urandom_range(0, 255));
        end
        pairs_done = 0;
        push_pairs(2);
        send_words(5);
        for (int i = 0; i < LEN; i++) begin
            line_u[0][i] = 8'($urandom_range(1, 255));
            line_u[1][i] = 8'($urandom_range(1, 255));
        end
        push_pairs(LEN);
        send_words(LEN);
        wait_empty();
        check("restart_pairs", 32'(pairs_done), LEN + 2);

        // Reset while the MAC is running
        send_words(4);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_out_even", 32'(out_even), 0);
        check("mid_rst_out_odd", 32'(out_odd), 0);
        check("mid_rst_in_ready", 32'(in_ready), 0);
        exp_q.delete();
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_release_ready", 32'(in_ready), 1);
        pairs_done = 0;
        repeat (30) @(negedge clk);
        check("mid_rst_quiet", 32'(out_valid), 0);
        check("mid_rst_no_pairs", 32'(pairs_done), 0);
        push_pairs(LEN);
        send_words(LEN);
        wait_empty();
        check("post_rst_pairs", 32'(pairs_done), LEN);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/chroma_fir_upsampler.md
# chroma_fir_upsampler

Parametrised, multi-channel 2x horizontal chroma upsampler for the decoder datapath. It accepts one line of decimated chroma samples per channel through a valid/ready stream and emits (even, odd) output pairs per input position. The odd sample comes from the 6-tap symmetric filter (21, -52, 159, 159, -52, 21, +128, >>8), clipped to the sample range. Line edges are handled by sample replication. A single shared multiplier is time-multiplexed across taps and channels.

## Interface
- DATA_W, 8, sample width (unsigned)
- CHANNELS, 2, independent chroma channels (U, V, ...) packed in one word; channel k occupies bits [k*DATA_W +: DATA_W]
- LINE_LEN, 160, input samples per line per channel (>= 4)
- C0, 21; C1, 52; C2, 159: tap magnitudes; kernel is +C0, -C1, +C2, +C2, -C1, +C0
- CLOCK_50_I  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  block accepts input this cycle
- in_sol  in  1  qualifies the input word as sample 0 of a new line
- in_data  in  CHANNELS*DATA_W  one sample per channel
- out_valid  out  1  output pair valid
- out_ready  in  1  downstream accepts the pair
- out_even  out  CHANNELS*DATA_W  u[j] per channel
- out_odd  out  CHANNELS*DATA_W  filtered u[j+0.5] per channel
- out_eol  out  1  qualifies the pair for j = LINE_LEN-1

## Operation
- Per channel there is a 6-entry window W[0..5] = u[j-2..j+3]. Shifting moves W[k] <= W[k+1] and W[5] <= the new sample.
- Indices are clamped to [0, LINE_LEN-1].
- FSM states: IDLE, LOAD, MAC, OUT, FLUSH.
- IDLE: in_ready=1.
  - A handshake with in_sol=1 loads all six entries of every channel with in_data, sets rx_cnt=1, and moves to LOAD.
  - A handshake without in_sol discards the word.
- LOAD: in_ready=1.
  - A handshake with in_sol=0 shifts in the word and increments rx_cnt.
  - When the handshake brings rx_cnt to >= 4, go to MAC.
  - A handshake with in_sol=1 restarts the line exactly as in IDLE. The aborted line produces no further output and no out_eol.
- MAC: 3*CHANNELS cycles, in_ready=0, channel-major. For each channel:
  - Step 0: acc = C0*(W0+W5) + 128.
  - Step 1: acc -= C1*(W1+W4).
  - Step 2: acc += C2*(W2+W3).
  - After step 2, latch that channel's odd result and out_even slice = W2.
- Arithmetic: sums are unsigned DATA_W+1 bits; acc is signed DATA_W+11 bits.
  - result = acc >>> 8 (arithmetic shift).
  - Clip: result < 0 -> 0; result > 2^DATA_W-1 -> 2^DATA_W-1.
- OUT: out_valid=1 until out_ready. On handshake:
  - If rx_cnt < LINE_LEN, go to LOAD.
  - Else if flush_cnt < 3, go to FLUSH.
  - Else clear counters and go to IDLE.
- FLUSH: one cycle, in_ready=0. Shifts W5 (last sample, replicated) into every window, increments flush_cnt, then goes to MAC.
- out_eol=1 on the pair produced after the third flush.
- Each line yields exactly LINE_LEN pairs, j = 0..LINE_LEN-1.

## Timing
- Reset values:
  - out_valid=0, out_eol=0, out_even=0, out_odd=0.
  - in_ready=0 while reset is asserted; 1 from the first cycle after release (IDLE).
  - FSM=IDLE; counters and windows = 0.
- Reset mid-operation discards the line in progress. No output is produced after reset deasserts until a new in_sol.
- Latency:
  - Accept of the sample that enters MAC at cycle t gives out_valid at t+3*CHANNELS+1.
  - Each flush adds 1 cycle before MAC.
- Outputs are registered and held stable while out_valid=1 and out_ready=0. in_ready stays 0 throughout MAC, OUT and FLUSH.
- in_ready is a pure state decode. in_data/in_sol are sampled only on in_valid & in_ready.
- Throughput with out_ready=1: one pair per 3*CHANNELS+2 cycles when input is always valid.

## Test plan
- Constant line, CHANNELS=2, ch0=100 and ch1=50 for all LINE_LEN=160 samples:
  - Expect 160 pairs, even=odd=100 on ch0 and 50 on ch1.
  - out_eol only on pair 160.
  - in_valid=1, out_ready=1 throughout, so pair spacing is exactly 8 cycles.
- Edges, LINE_LEN=8, ch0 input 10,20,...,80:
  - Pair j=0: odd=15, even=10.
  - Pair j=7: odd=80, even=80, out_eol=1.
  - 8 pairs total.
- Clipping, LINE_LEN=8, ch0 input 0,0,255,255,0,0,0,0:
  - Pair j=2 (window 0,0,255,255,0,0): odd=255; the raw result of 317 is clipped.
  - Input 255,255,0,0,255,255,255,255 at j=2: odd=0; the raw result of -62 is clipped.
- Backpressure: hold out_ready=0 for 5 cycles on pair j=3.
  - out_valid, out_even and out_odd stay constant.
  - in_ready=0 throughout.
  - No pair is lost or duplicated.
- Restart and stray data:
  - A word without in_sol while in IDLE produces no output.
  - In a LINE_LEN=8 run, an in_sol word after 5 samples discards the aborted line.
  - The next 8 pairs match the new line with a single out_eol.
- Reset: assert reset during MAC.
  - Next cycle shows out_valid=0, out_even=0, out_odd=0.
  - After release, in_ready=1 and no output appears until a new in_sol.
